// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } imem_loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into 32-bit words. The first three bytes
// of a word are held in a shift register; the fourth byte is taken straight
// from the input, so `word`/`word_valid` are presented in the same cycle the
// last byte is accepted. Used for length, data and checksum words alike.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_fire,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]       sh_q, sh_d;

    // Advance byte count and shift in the byte on every accepted transfer.
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clear) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (in_fire) begin
            cnt_d = cnt_q + BCNT_W'(1);
            sh_d  = {sh_q[15:0], in_byte};
        end
    end

    assign word       = {sh_q, in_byte};
    assign word_valid = in_fire && !clear && (cnt_q == BCNT_W'(WORD_BYTES - 1));

    // Byte counter and partial-word storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length word, N data words written at
// word addresses 0..N-1, optional trailing checksum word. Holds the CPU in
// reset until a complete image has landed.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds CSUM state + sum).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    imem_loader_state_t state_q, state_d;
    logic [ADDR_W:0]    n_q, n_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [31:0]        im_wdata_q, im_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]        sum_q, sum_d;
`endif

    logic        fire, pk_clear, pk_valid, last_word;
    logic [31:0] pk_word;

    assign busy      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign in_ready  = busy;
    assign fire      = in_valid && in_ready;
    // A fresh load always starts from an empty packer.
    assign pk_clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_word = ({1'b0, idx_q} == (n_q - (ADDR_W + 1)'(1)));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .in_fire    (fire),
        .in_byte    (in_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // Next-state and next-output logic for the load sequencer.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LEN;
                    idx_d      = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            ST_LEN: begin
                if (pk_valid) begin
                    n_d = pk_word[ADDR_W:0];
                    if (pk_word > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (pk_word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pk_valid) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = idx_q;
                    im_wdata_d = pk_word;
                    idx_d      = idx_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + pk_word;
                    if (last_word) state_d = ST_CSUM;
`else
                    if (last_word) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (pk_valid) begin
                    state_d = ST_DONE;
                    if (pk_word == sum_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand sequences for
// reset/start corner cases, and random streams against a stream-level model.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk, rst, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, im_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef logic [7:0] bq_t[$];
    typedef logic [ADDR_W+31:0] wr_t;
    wr_t cap_q[$];

    // Every write seen on the memory port, sampled mid-cycle.
    always @(negedge clk) if (im_we === 1'b1) cap_q.push_back({im_addr, im_wdata});

    // Reference model results.
    logic [31:0] exp_words[$];
    logic        exp_done, exp_err, exp_hold, exp_ok;
    logic [31:0] exp_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic void push_word(inout bq_t q, input logic [31:0] w);
        q.push_back(w[31:24]); q.push_back(w[23:16]);
        q.push_back(w[15:8]);  q.push_back(w[7:0]);
    endfunction

    function automatic logic [31:0] get_word(input bq_t q, input int at);
        return {q[at], q[at+1], q[at+2], q[at+3]};
    endfunction

    // Interprets a whole stream by the format rules.
    function automatic void model(input bq_t bs);
        logic [31:0] sum, w;
        exp_words.delete();
        sum   = '0;
        exp_n = get_word(bs, 0);
        exp_ok = (exp_n <= 32'(DEPTH));
        if (exp_ok) begin
            for (int i = 0; i < int'(exp_n); i++) begin
                w = get_word(bs, 4 + 4 * i);
                exp_words.push_back(w);
                sum += w;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_done = exp_ok && (get_word(bs, 4 + 4 * int'(exp_n)) == sum);
`else
        exp_done = exp_ok;
`endif
        exp_err  = !exp_done;
        exp_hold = !exp_done;
    endfunction

    function automatic logic is_last_data(input int k);
        return exp_ok && k >= 4 && k < 4 + 4 * int'(exp_n) && (k % 4) == 3;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. mid_k: pulse start with byte mid_k.
    task automatic run_stream(input bq_t bs, input int vmode, input int mid_k, input bit do_start);
        int k, cyc;
        logic v, rdy;
        bit mid_done;
        model(bs);
        cap_q.delete();
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("ready_after_start", in_ready, 1);
        end
        k = 0; cyc = 0; mid_done = 0;
        while (k < bs.size()) begin
            if (cyc > 8 * bs.size() + 20) begin
                tests++; fails++;
                $display("FAIL stream_timeout: got %0d bytes accepted want %0d", k, bs.size());
                break;
            end
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = bs[k];
            start    = (k == mid_k) && !mid_done;
            if (start) mid_done = 1;
            rdy = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (v && rdy) begin
                chk($sformatf("im_we_byte%0d", k), im_we, is_last_data(k));
                k++;
            end else begin
                chk("im_we_nofire", im_we, 0);
            end
        end
        in_valid = 1'b0;
        chk("final_done", done, exp_done);
        chk("final_err", err, exp_err);
        chk("final_hold", cpu_hold, exp_hold);
        chk("final_busy", busy, 0);
        @(posedge clk); #1;
        chk("after_ready", in_ready, 0);
        chk("after_we", im_we, 0);
        chk("write_count", cap_q.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < cap_q.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), 32'(cap_q[i][ADDR_W+31:32]), i);
            chk($sformatf("wr_data%0d", i), cap_q[i][31:0], exp_words[i]);
        end
    endtask

    typedef struct {
        logic [31:0] n, w0, w1, cs;
        int          vmode;
        logic        e_done, e_err, e_hold;
        int          e_nwr;
    } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int NV = 5;
`else
    localparam int NV = 4;
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[NV];
        bq_t  bs;
        logic [31:0] sum, w;
        int   n;

        vt[0] = '{32'd2, 32'h1064FFFF, 32'hAFA6FFFC, 32'hC00BFFFB, 0, 1'b1, 1'b0, 1'b0, 2};
        vt[1] = '{32'd2, 32'h1064FFFF, 32'hAFA6FFFC, 32'hC00BFFFB, 1, 1'b1, 1'b0, 1'b0, 2};
        vt[2] = '{32'h401, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b1, 0};
        vt[3] = '{32'd0, 32'h0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 0};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vt[4] = '{32'd2, 32'h1064FFFF, 32'hAFA6FFFC, 32'hC00BFFFA, 0, 1'b0, 1'b1, 1'b1, 2};
`endif

        // Reset state.
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", im_we, 0);
        chk("rst_addr", 32'(im_addr), 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Table vectors.
        for (int t = 0; t < NV; t++) begin
            do_reset();
            bs.delete();
            push_word(bs, vt[t].n);
            if (vt[t].n <= 32'(DEPTH)) begin
                if (vt[t].n >= 1) push_word(bs, vt[t].w0);
                if (vt[t].n >= 2) push_word(bs, vt[t].w1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                push_word(bs, vt[t].cs);
`endif
            end
            run_stream(bs, vt[t].vmode, -1, 1);
            chk($sformatf("vec%0d_done", t), done, vt[t].e_done);
            chk($sformatf("vec%0d_err", t), err, vt[t].e_err);
            chk($sformatf("vec%0d_hold", t), cpu_hold, vt[t].e_hold);
            chk($sformatf("vec%0d_nwr", t), cap_q.size(), vt[t].e_nwr);
            if (vt[t].e_nwr >= 1 && cap_q.size() >= 1)
                chk($sformatf("vec%0d_w0", t), cap_q[0][31:0], vt[t].w0);
        end

        // Reset after two data bytes, then a clean N=1 load.
        do_reset();
        cap_q.delete();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        bs.delete();
        push_word(bs, 32'd1); bs.push_back(8'hAA); bs.push_back(8'hBB);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = bs[i];
            @(posedge clk); #1;
        end
        rst = 1'b1; in_data = 8'hCC;
        @(posedge clk); #1;
        chk("midrst_we", im_we, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_hold", cpu_hold, 1);
        chk("midrst_addr", 32'(im_addr), 0);
        chk("midrst_wdata", im_wdata, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_nowrites", cap_q.size(), 0);
        bs.delete();
        push_word(bs, 32'd1); push_word(bs, 32'h0000000C);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(bs, 32'h0000000C);
`endif
        run_stream(bs, 0, -1, 1);
        chk("midrst_reload_nwr", cap_q.size(), 1);
        if (cap_q.size() >= 1) chk("midrst_reload_w", cap_q[0][31:0], 32'h0000000C);

        // Start pulsed mid-DATA is ignored.
        do_reset();
        bs.delete();
        push_word(bs, 32'd2); push_word(bs, 32'h1064FFFF); push_word(bs, 32'hAFA6FFFC);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(bs, 32'hC00BFFFB);
`endif
        run_stream(bs, 0, 6, 1);
        chk("midstart_done", done, 1);

        // Start in DONE clears status; N=0 reload sets done again, no writes.
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        chk("restart_done_clr", done, 0);
        chk("restart_hold", cpu_hold, 1);
        chk("restart_busy", busy, 1);
        bs.delete();
        push_word(bs, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(bs, 32'd0);
`endif
        run_stream(bs, 0, -1, 0);
        chk("restart_n0_done", done, 1);
        chk("restart_n0_nwr", cap_q.size(), 0);

        // Random streams, chained back to back from DONE.
        do_reset();
        for (int r = 0; r < 12; r++) begin
            bs.delete();
            n = (r % 6 == 5) ? DEPTH + 1 + $urandom_range(0, 3) : $urandom_range(0, 5);
            push_word(bs, 32'(n));
            sum = '0;
            if (n <= DEPTH) begin
                for (int i = 0; i < n; i++) begin
                    w = $urandom;
                    push_word(bs, w);
                    sum += w;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                push_word(bs, ($urandom_range(0, 2) == 0) ? sum + 32'd1 : sum);
`endif
            end
            run_stream(bs, 2, ($urandom_range(0, 1) == 1) ? 5 : -1, 1);
        end

        // Largest image that fits: N = 2^ADDR_W.
        bs.delete();
        push_word(bs, 32'(DEPTH));
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            push_word(bs, w);
            sum += w;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(bs, sum);
`endif
        run_stream(bs, 0, -1, 1);
        chk("full_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
